// File: rtl/alu_if.sv
// Operand, result and flag bundle between the CPU datapath and the ALU.
// The master side drives operands and opcode; the slave (the ALU) drives
// the combinational result/flags and their registered copies.
interface alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [2:0]            ALUop;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;
  logic [DATA_WIDTH-1:0] Result_q;
  logic [2:0]            Flags_q;

  modport master (
    output A, B, ALUop,
    input  Result, Overflow, CarryOut, Zero, Result_q, Flags_q
  );

  modport slave (
    input  A, B, ALUop,
    output Result, Overflow, CarryOut, Zero, Result_q, Flags_q
  );
endinterface

// File: rtl/alu.sv
// Integer ALU for the single-cycle CPU: AND, OR, ADD, SUB and signed SLT.
// Result and flags are combinational; a one-cycle registered copy of all
// outputs is kept for pipelined/debug consumers and cleared by resetn.
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input logic   clk,
  input logic   resetn,
  alu_if.slave  bus
);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic                  sub_mode;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;
  logic                  ovf_add;
  logic                  ovf_sub;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow;
  logic                  carryout;
  logic                  zero;

  // Shared adder: SUB and SLT reuse it as A + ~B + 1, so both overflow
  // conditions come from the same sum and SLT stays correct on overflow.
  always_comb begin
    sub_mode = (bus.ALUop == OP_SUB) || (bus.ALUop == OP_SLT);
    b_eff    = sub_mode ? ~bus.B : bus.B;
    {cout, sum} = {1'b0, bus.A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_mode};
    ovf_add  = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
    ovf_sub  = (bus.A[MSB] != bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
  end

  // Opcode decode; undefined opcodes yield a zero result with clear flags.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    carryout = 1'b0;
    case (bus.ALUop)
      OP_AND: result = bus.A & bus.B;
      OP_OR:  result = bus.A | bus.B;
      OP_ADD: begin
        result   = sum;
        carryout = cout;
        overflow = ovf_add;
      end
      OP_SUB: begin
        result   = sum;
        carryout = ~cout;
        overflow = ovf_sub;
      end
      OP_SLT: result = {{(DATA_WIDTH-1){1'b0}}, sum[MSB] ^ ovf_sub};
      default: result = '0;
    endcase
    zero = ~|result;
  end

  assign bus.Result   = result;
  assign bus.Overflow = overflow;
  assign bus.CarryOut = carryout;
  assign bus.Zero     = zero;

  // Registered copy of every output; cleared immediately when resetn drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.Result_q <= '0;
      bus.Flags_q  <= 3'b000;
    end else begin
      bus.Result_q <= result;
      bus.Flags_q  <= {overflow, carryout, zero};
    end
  end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, registered-stage and
// asynchronous reset sequences, then random operations against a model
// computed with plain wide/signed arithmetic.
module tb_alu;
  logic clk;
  logic resetn;

  alu_if #(.DATA_WIDTH(32)) bus ();

  alu #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [2:0] flags);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.flags = flags;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUop = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // Reference: signed overflow detected by range, carry/borrow from wide or
  // unsigned comparison, SLT from signed comparison.
  function automatic exp_t refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, sd;
    logic [32:0] wide;
    logic        ovf, cy;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    cy  = 1'b0;
    r   = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[31:0];
        cy   = wide[32];
        sd   = sa + sb;
        ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      3'b110: begin
        r   = a - b;
        cy  = (a < b);
        sd  = sa - sb;
        ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    e.res   = r;
    e.flags = {ovf, cy, (r == 32'd0)};
    return e;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [2:0] ops [8];
    exp_t       e;
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    // flags are {Overflow, CarryOut, Zero}
    addVec("add_1_1",        3'b010, 32'd1,          32'd1,      32'd2,          3'b000);
    addVec("add_88_5",       3'b010, 32'd88,         32'd5,      32'd93,         3'b000);
    addVec("add_ovf",        3'b010, 32'h7FFF_FFFF,  32'd1,      32'h8000_0000,  3'b100);
    addVec("add_carry",      3'b010, 32'hFFFF_FFFF,  32'd1,      32'h0000_0000,  3'b011);
    addVec("sub_1555_111",   3'b110, 32'd1555,       32'd111,    32'd1444,       3'b000);
    addVec("sub_equal",      3'b110, 32'd111,        32'd111,    32'd0,          3'b001);
    addVec("sub_borrow",     3'b110, 32'd1555,       32'd11111,  32'hFFFF_DAAC,  3'b010);
    addVec("sub_1_2",        3'b110, 32'd1,          32'd2,      32'hFFFF_FFFF,  3'b010);
    addVec("sub_ovf",        3'b110, 32'h8000_0000,  32'd1,      32'h7FFF_FFFF,  3'b100);
    addVec("and",            3'b000, 32'd1555,       32'd11111,  32'd515,        3'b000);
    addVec("or",             3'b001, 32'd1555,       32'd11111,  32'd12151,      3'b000);
    addVec("and_zero",       3'b000, 32'hF0F0_F0F0,  32'h0F0F_0F0F, 32'd0,       3'b001);
    addVec("slt_lt",         3'b111, 32'd1555,       32'd11111,  32'd1,          3'b000);
    addVec("slt_ge",         3'b111, 32'd11111,      32'd33,     32'd0,          3'b001);
    addVec("slt_neg1_1",     3'b111, 32'hFFFF_FFFF,  32'd1,      32'd1,          3'b000);
    addVec("slt_neg1_2",     3'b111, 32'hFFFF_FFFF,  32'd2,      32'd1,          3'b000);
    addVec("slt_min_1",      3'b111, 32'h8000_0000,  32'd1,      32'd1,          3'b000);
    addVec("slt_max_min",    3'b111, 32'h7FFF_FFFF,  32'h8000_0000, 32'd0,       3'b001);
    addVec("undef_100",      3'b100, 32'd5,          32'd7,      32'd0,          3'b001);
    addVec("undef_011",      3'b011, 32'hFFFF_FFFF,  32'd1,      32'd0,          3'b001);
    addVec("undef_101",      3'b101, 32'd1555,       32'd11111,  32'd0,          3'b001);

    // Reset state: registers clear while resetn is low.
    resetn = 1'b0;
    applyStimulus(3'b010, 32'd1, 32'd1);
    #3;
    checkOutput("reset_result_q", bus.Result_q, 32'd0);
    checkOutput("reset_flags_q", {29'd0, bus.Flags_q}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors: combinational outputs, then the registered copy.
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      checkOutput({vecs[i].name, "_result"}, bus.Result, vecs[i].res);
      checkOutput({vecs[i].name, "_flags"}, {29'd0, bus.Overflow, bus.CarryOut, bus.Zero},
                  {29'd0, vecs[i].flags});
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_result_q"}, bus.Result_q, vecs[i].res);
      checkOutput({vecs[i].name, "_flags_q"}, {29'd0, bus.Flags_q}, {29'd0, vecs[i].flags});
    end

    // Registered stage holds ADD 88+5, then reset drops mid-cycle.
    @(negedge clk);
    applyStimulus(3'b010, 32'd88, 32'd5);
    @(posedge clk);
    #1;
    checkOutput("seq_add_result_q", bus.Result_q, 32'd93);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_result_q", bus.Result_q, 32'd0);
    checkOutput("async_reset_flags_q", {29'd0, bus.Flags_q}, 32'd0);
    checkOutput("comb_during_reset", bus.Result, 32'd93);
    // Edges while held in reset must not load the registers.
    applyStimulus(3'b110, 32'd1, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("held_reset_result_q", bus.Result_q, 32'd0);
    checkOutput("held_reset_flags_q", {29'd0, bus.Flags_q}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("release_no_edge_result_q", bus.Result_q, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("release_capture_result_q", bus.Result_q, 32'hFFFF_FFFF);
    checkOutput("release_capture_flags_q", {29'd0, bus.Flags_q}, 32'd2);

    // Random operations against the reference model, one per cycle.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 7)];
      a  = pickOperand();
      b  = pickOperand();
      e  = refModel(op, a, b);
      @(negedge clk);
      applyStimulus(op, a, b);
      #1;
      checkOutput("rand_result", bus.Result, e.res);
      checkOutput("rand_flags", {29'd0, bus.Overflow, bus.CarryOut, bus.Zero}, {29'd0, e.flags});
      @(posedge clk);
      #1;
      checkOutput("rand_result_q", bus.Result_q, e.res);
      checkOutput("rand_flags_q", {29'd0, bus.Flags_q}, {29'd0, e.flags});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
